// File: rtl/dmem_lsu_arb_if.sv
// Request/response and data-memory bus between the LSU arbiter and its clients.
// The slave side is the arbiter; the master side drives requests and memory read data.
interface dmem_lsu_arb_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [2:0]  req_funct3_p0;
  logic [2:0]  req_funct3_p1;
  logic [31:0] req_addr_p0;
  logic [31:0] req_addr_p1;
  logic [31:0] req_wdata_p0;
  logic [31:0] req_wdata_p1;
  logic        rsp_valid;
  logic        rsp_port;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3_p0, req_funct3_p1,
    input  req_addr_p0, req_addr_p1, req_wdata_p0, req_wdata_p1, mem_rdata,
    output req_ready, rsp_valid, rsp_port, rsp_rdata, rsp_err,
    output mem_addr, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3_p0, req_funct3_p1,
    output req_addr_p0, req_addr_p1, req_wdata_p0, req_wdata_p1, mem_rdata,
    input  req_ready, rsp_valid, rsp_port, rsp_rdata, rsp_err,
    input  mem_addr, mem_write, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu_arb.sv
// Two-port round-robin load/store controller for a word-wide single-port data memory.
// Sub-word stores are read-modify-write; loads are sign/zero extended.
module dmem_lsu_arb #(
  parameter int DEPTH = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_lsu_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  state_t      state_q, state_d;
  logic        live_q, live_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_port_q, rsp_port_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant;
  logic        handshake;
  logic        acc_err;
  logic        sw_commit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [3:0]  lane_hit;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    if (&bus.req_valid) grant = ~last_grant_q;
    else                grant = bus.req_valid[1];
  end

  // live_q keeps ready low until the first edge after reset release.
  assign handshake     = (state_q == S_IDLE) && live_q && (|bus.req_valid);
  assign bus.req_ready = handshake ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    acc_err = 1'b0;
    if ({1'b0, addr_q} >= ADDR_LIMIT)                               acc_err = 1'b1;
    if ((funct3_q == 3'd1 || funct3_q == 3'd5) && addr_q[0])        acc_err = 1'b1;
    if (funct3_q == 3'd2 && addr_q[1:0] != 2'b00)                   acc_err = 1'b1;
    if (!we_q && (funct3_q == 3'd3 || funct3_q == 3'd6 || funct3_q == 3'd7)) acc_err = 1'b1;
    if (we_q && funct3_q > 3'd2)                                    acc_err = 1'b1;
  end

  assign byte_sel = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (funct3_q)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // Byte-lane merge for SB/SH: each lane takes store data or keeps the old memory byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] src;
      assign lane_hit[gi] = (funct3_q[1:0] == 2'd0) ? (addr_q[1:0] == LANE)
                                                    : (addr_q[1] == LANE[1]);
      assign src = (funct3_q[1:0] == 2'd0) ? wdata_q[7:0] : wdata_q[8*(gi%2) +: 8];
      assign merged_word[8*gi +: 8] = lane_hit[gi] ? src : bus.mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    live_d       = 1'b1;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_port_d   = rsp_port_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          last_grant_d = grant;
          port_d       = grant;
          we_d         = bus.req_we[grant];
          funct3_d     = grant ? bus.req_funct3_p1 : bus.req_funct3_p0;
          addr_d       = grant ? bus.req_addr_p1   : bus.req_addr_p0;
          wdata_d      = grant ? bus.req_wdata_p1  : bus.req_wdata_p0;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rsp_port_d  = port_q;
        rsp_err_d   = acc_err;
        rsp_rdata_d = (we_q || acc_err) ? 32'd0 : load_data;
        if (!acc_err && we_q && funct3_q != 3'd2) begin
          wdata_d = merged_word;
          state_d = S_MERGE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_MERGE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      live_q       <= 1'b0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      live_q       <= live_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Write strobe decodes from state so an asynchronous reset drops it immediately.
  assign sw_commit     = (state_q == S_ACCESS) && we_q && (funct3_q == 3'd2) && !acc_err;
  assign bus.mem_write = sw_commit || (state_q == S_MERGE);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_port  = rsp_port_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu_arb.sv
// Directed bench for dmem_lsu_arb: vector table plus round-robin and reset-abort sequences.
// A behavioural word memory sits on the memory side of the bus.
module tb_dmem_lsu_arb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_lsu_arb_if bus ();

  dmem_lsu_arb #(.DEPTH(1024)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  bit [31:0] mem [0:1023];
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
  always @(posedge clk) if (bus.mem_write === 1'b1) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;

  int wr_count   = 0;
  int stray      = 0;
  int twohot     = 0;
  int wr_in_resp = 0;
  always @(posedge clk) if (bus.mem_write === 1'b1) wr_count <= wr_count + 1;
  always @(negedge clk) begin
    if ((bus.req_ready & ~bus.req_valid) != 2'b00) stray <= stray + 1;
    if (bus.req_ready == 2'b11) twohot <= twohot + 1;
    if (bus.mem_write === 1'b1 && bus.rsp_valid === 1'b1) wr_in_resp <= wr_in_resp + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    bit        port;
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        lat;
    bit        err;
    bit [31:0] rdata;
    string     name;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [0:NV-1];

  task automatic drive(input bit port, input bit we, input bit [2:0] f3,
                       input bit [31:0] addr, input bit [31:0] wdata);
    bus.req_we[port] = we;
    if (port) begin
      bus.req_funct3_p1 = f3; bus.req_addr_p1 = addr; bus.req_wdata_p1 = wdata;
    end else begin
      bus.req_funct3_p0 = f3; bus.req_addr_p0 = addr; bus.req_wdata_p0 = wdata;
    end
    bus.req_valid[port] = 1'b1;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int w0;
    drive(v.port, v.we, v.f3, v.addr, v.wdata);
    #1;
    for (int i = 0; i < 20 && !bus.req_ready[v.port]; i++) begin
      @(posedge clk); #1;
    end
    chk({v.name, " ready"}, 32'(bus.req_ready[v.port]), 32'd1);
    w0 = wr_count;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("vec %0d %s: port=%0d lat=%0d err=%0d rdata=0x%08h", idx, v.name,
             bus.rsp_port, lat, bus.rsp_err, bus.rsp_rdata);
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
    chk({v.name, " rsp_rdata"}, bus.rsp_rdata, v.rdata);
    chk({v.name, " rsp_port"}, 32'(bus.rsp_port), 32'(v.port));
    @(posedge clk); #1;
    chk({v.name, " rsp_valid one cycle"}, 32'(bus.rsp_valid), 32'd0);
    chk({v.name, " write pulses"}, 32'(wr_count - w0), (v.we && !v.err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int g[4], gc[4], rp[4];
    logic [31:0] rd[4];
    int ng, nr, seen, w0;
    vec_t v;

    vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 2, 1'b0, 32'h0,        "SW 0x10"};
    vecs[1]  = '{1'b0, 1'b0, 3'd2, 32'h10,   32'h0,        2, 1'b0, 32'hDEADBEEF, "LW 0x10"};
    vecs[2]  = '{1'b0, 1'b1, 3'd0, 32'h11,   32'h000000A5, 3, 1'b0, 32'h0,        "SB 0x11"};
    vecs[3]  = '{1'b0, 1'b0, 3'd2, 32'h10,   32'h0,        2, 1'b0, 32'hDEADA5EF, "LW after SB"};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 32'h11,   32'h0,        2, 1'b0, 32'hFFFFFFA5, "LB 0x11"};
    vecs[5]  = '{1'b0, 1'b0, 3'd4, 32'h11,   32'h0,        2, 1'b0, 32'h000000A5, "LBU 0x11"};
    vecs[6]  = '{1'b0, 1'b0, 3'd5, 32'h12,   32'h0,        2, 1'b0, 32'h0000DEAD, "LHU 0x12"};
    vecs[7]  = '{1'b0, 1'b0, 3'd1, 32'h10,   32'h0,        2, 1'b0, 32'hFFFFA5EF, "LH 0x10"};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 32'h10,   32'h0,        2, 1'b0, 32'hFFFFFFEF, "LB 0x10"};
    vecs[9]  = '{1'b0, 1'b1, 3'd1, 32'h13,   32'h00001234, 2, 1'b1, 32'h0,        "SH 0x13 misaligned"};
    vecs[10] = '{1'b0, 1'b0, 3'd2, 32'h1000, 32'h0,        2, 1'b1, 32'h0,        "LW 0x1000 range"};
    vecs[11] = '{1'b0, 1'b0, 3'd3, 32'h10,   32'h0,        2, 1'b1, 32'h0,        "load f3=3"};
    vecs[12] = '{1'b0, 1'b0, 3'd2, 32'h10,   32'h0,        2, 1'b0, 32'hDEADA5EF, "LW after errors"};
    vecs[13] = '{1'b1, 1'b1, 3'd1, 32'h22,   32'h0000BEEF, 3, 1'b0, 32'h0,        "P1 SH 0x22"};
    vecs[14] = '{1'b1, 1'b0, 3'd1, 32'h22,   32'h0,        2, 1'b0, 32'hFFFFBEEF, "P1 LH 0x22"};
    vecs[15] = '{1'b1, 1'b0, 3'd2, 32'h20,   32'h0,        2, 1'b0, 32'hBEEF0000, "P1 LW 0x20"};
    vecs[16] = '{1'b1, 1'b1, 3'd0, 32'h23,   32'h1234567F, 3, 1'b0, 32'h0,        "P1 SB 0x23"};
    vecs[17] = '{1'b1, 1'b0, 3'd0, 32'h23,   32'h0,        2, 1'b0, 32'h0000007F, "P1 LB 0x23"};
    vecs[18] = '{1'b1, 1'b0, 3'd4, 32'h20,   32'h0,        2, 1'b0, 32'h00000000, "P1 LBU 0x20"};
    vecs[19] = '{1'b1, 1'b0, 3'd1, 32'h21,   32'h0,        2, 1'b1, 32'h0,        "P1 LH 0x21 misaligned"};
    vecs[20] = '{1'b1, 1'b1, 3'd4, 32'h20,   32'hFFFFFFFF, 2, 1'b1, 32'h0,        "P1 store f3=4"};
    vecs[21] = '{1'b1, 1'b1, 3'd2, 32'hFFC,  32'h12345678, 2, 1'b0, 32'h0,        "P1 SW top word"};
    vecs[22] = '{1'b1, 1'b0, 3'd2, 32'hFFC,  32'h0,        2, 1'b0, 32'h12345678, "P1 LW top word"};
    vecs[23] = '{1'b1, 1'b0, 3'd0, 32'h1000, 32'h0,        2, 1'b1, 32'h0,        "P1 LB 0x1000 range"};
    vecs[24] = '{1'b1, 1'b0, 3'd2, 32'h20,   32'h0,        2, 1'b0, 32'h7FEF0000, "P1 LW 0x20 final"};

    bus.req_valid = 2'b11;
    bus.req_we = 2'b00;
    bus.req_funct3_p0 = 3'd2; bus.req_funct3_p1 = 3'd2;
    bus.req_addr_p0 = 32'h0;  bus.req_addr_p1 = 32'h0;
    bus.req_wdata_p0 = 32'h0; bus.req_wdata_p1 = 32'h0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_port", 32'(bus.rsp_port), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset mem_write", 32'(bus.mem_write), 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready low right after release", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Round-robin: both ports hold loads; last grant was port 1 so port 0 goes first.
    for (int i = 0; i < 4; i++) begin g[i] = -1; gc[i] = -1; rp[i] = -1; rd[i] = 32'hx; end
    ng = 0; nr = 0;
    drive(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
    #1;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      if (bus.req_ready != 2'b00 && ng < 4) begin
        g[ng] = int'(bus.req_ready[1]); gc[ng] = c; ng++;
      end
      if (bus.rsp_valid === 1'b1) begin
        rp[nr] = int'(bus.rsp_port); rd[nr] = bus.rsp_rdata; nr++;
        $display("rr response %0d: port=%0d rdata=0x%08h", nr - 1, bus.rsp_port, bus.rsp_rdata);
      end
      if (nr < 4) begin @(posedge clk); #1; end
    end
    bus.req_valid = 2'b00;
    chk("rr grant count", 32'(ng), 32'd4);
    chk("rr response count", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr grant %0d", i), 32'(g[i]), 32'(i % 2));
      chk($sformatf("rr rsp_port %0d", i), 32'(rp[i]), 32'(i % 2));
      chk($sformatf("rr rdata %0d", i), rd[i], (i % 2 == 1) ? 32'h7FEF0000 : 32'hDEADA5EF);
      if (i > 0) chk($sformatf("rr spacing %0d", i), 32'(gc[i] - gc[i-1]), 32'd3);
    end
    @(posedge clk); #1;

    // Reset asserted while an SB sits in ACCESS: no write, no response.
    drive(1'b0, 1'b1, 3'd0, 32'h11, 32'h0000005A);
    #1;
    for (int i = 0; i < 20 && !bus.req_ready[0]; i++) begin @(posedge clk); #1; end
    chk("abort SB ready", 32'(bus.req_ready[0]), 32'd1);
    w0 = wr_count;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    reset_n = 1'b0;
    #1;
    chk("abort mem_write", 32'(bus.mem_write), 32'd0);
    chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("abort rsp_port", 32'(bus.rsp_port), 32'd0);
    chk("abort mem_addr", bus.mem_addr, 32'd0);
    chk("abort mem_wdata", bus.mem_wdata, 32'd0);
    chk("abort req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen++;
    end
    $display("abort SB @0x11: responses=%0d writes=%0d word=0x%08h", seen, wr_count - w0, mem[4]);
    chk("abort no response", 32'(seen), 32'd0);
    chk("abort no write", 32'(wr_count - w0), 32'd0);
    chk("abort word unchanged", mem[4], 32'hDEADA5EF);
    v = '{1'b0, 1'b0, 3'd2, 32'h10, 32'h0, 2, 1'b0, 32'hDEADA5EF, "LW after abort"};
    run_vec(NV, v);
    v = '{1'b0, 1'b0, 3'd4, 32'h11, 32'h0, 2, 1'b0, 32'h000000A5, "LBU after abort"};
    run_vec(NV + 1, v);

    chk("ready to non-requesting port", 32'(stray), 32'd0);
    chk("ready on both ports", 32'(twohot), 32'd0);
    chk("mem_write during RESP", 32'(wr_in_resp), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_arb.md
# dmem_lsu_arb

Load/store controller and two-port arbiter in front of the single-port, word-wide data memory (`data_mem`). It accepts byte, halfword and word accesses from the core (port 0) and from a DMA/debug master (port 1), chosen by round-robin. It performs sub-word stores as read-modify-write sequences, because the memory has no byte enables. It returns sign- or zero-extended load data and flags misaligned, illegal or out-of-range accesses.

## Interface
- `DEPTH`, 1024: memory depth in 32-bit words. Valid byte addresses are 0 .. 4*DEPTH-1.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid[1:0]` in 2: per-port request valid.
- `req_ready[1:0]` out 2: per-port accept. A request is taken when valid and ready are both high.
- `req_we[1:0]` in 2: per-port write (1 = store).
- `req_funct3_p0`, `req_funct3_p1` in 3 each: RISC-V funct3 (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2).
- `req_addr_p0`, `req_addr_p1` in 32 each: byte address.
- `req_wdata_p0`, `req_wdata_p1` in 32 each: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_port` out 1: port the response belongs to.
- `rsp_rdata` out 32: extended load data. 0 for stores and errors.
- `rsp_err` out 1: access rejected; memory is not modified.
- `mem_addr` out 32: word-aligned byte address, {addr[31:2],2'b00}.
- `mem_write` out 1: memory write enable.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: combinational read data for `mem_addr`.

## Operation
- **FSM states:** IDLE, ACCESS, MERGE, RESP.
- **IDLE:**
  - `req_ready` is high only toward the arbitration winner; the other bit is 0.
  - On handshake, latch port, we, funct3, addr and wdata, then go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration:**
  - If one port is valid, that port wins.
  - If both are valid, the port other than `last_grant` wins. `last_grant` updates on every handshake.
  - Reset value of `last_grant` is 1, so port 0 wins the first tie.
- **Requester rule:** hold all request fields stable while valid and not ready.
- **Error check** (combinational on latched fields, evaluated in ACCESS). Error if any of:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Load funct3 ∈ {3,6,7}.
  - Store funct3 ∉ {0,1,2}.
  - addr ≥ 4*DEPTH.

  On error there is no `mem_write`, and the FSM goes ACCESS→RESP with `rsp_err`=1.
- **Load:**
  - In ACCESS, select the byte or half of `mem_rdata` at addr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Register the result into `rsp_rdata`, then go to RESP.
- **SW:** in ACCESS, `mem_write`=1 with `mem_wdata`=wdata, then go to RESP.
- **SB/SH:**
  - In ACCESS, read `mem_rdata` and replace lane byte addr[1:0] (or half addr[1]) with wdata[7:0] (or [15:0]).
  - Register the merged word into `mem_wdata`, then go to MERGE.
  - In MERGE, `mem_write`=1, then go to RESP.
- **RESP:** `rsp_valid`=1 for exactly one cycle with `rsp_port`, `rsp_rdata` and `rsp_err`, then go to IDLE. The controller has no response backpressure.
- **Reset values:** state IDLE; `req_ready`=0 on both ports until the first cycle after reset release; `rsp_valid`=0, `rsp_port`=0, `rsp_rdata`=0, `rsp_err`=0; `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- **Reset mid-operation:** return to IDLE immediately and drop `mem_write` asynchronously. A sub-word store cut before MERGE leaves the memory word unchanged. No response is issued for the aborted request.

## Timing
- Handshake at edge T.
  - Load, SW and error cases: `rsp_valid` high in cycle T+2.
  - SB/SH: `rsp_valid` high in cycle T+3.
- The next request can be accepted at the edge ending the cycle after RESP (back-to-back loads: one every 3 cycles).
- `mem_write` is asserted for exactly one cycle per successful store: ACCESS for SW, MERGE for SB/SH. It is never asserted in IDLE or RESP.
- `mem_addr` holds the latched word address from ACCESS through MERGE.
- Only one outstanding request exists at a time; requests are never reordered.

## Test plan
- **Word store then load:** after reset, port 0 SW 0xDEADBEEF @0x10, then LW @0x10. Expect `rsp_valid` at T+2 with `rsp_err`=0, and LW `rsp_rdata`=0xDEADBEEF.
- **Sub-word store and extending loads:** SB 0x000000A5 @0x11 responds at T+3 and the memory word becomes 0xDEADA5EF. Then:
  - LB @0x11 → 0xFFFFFFA5.
  - LBU @0x11 → 0x000000A5.
  - LHU @0x12 → 0x0000DEAD.
- **Errors:** each of the following gives `rsp_err`=1 at T+2, `rsp_rdata`=0, `mem_write` never asserted, and memory unchanged:
  - SH @0x13.
  - LW @0x1000 (DEPTH=1024).
  - Load funct3=3.
- **Round-robin:** both ports hold `req_valid` continuously with loads. Grants alternate 0,1,0,1, and `rsp_port` follows the same order.
- **Reset during a sub-word store:** assert `reset_n` low in ACCESS of SB @0x11. Expect no `mem_write` pulse, all outputs at reset values, no `rsp_valid`, and the word at 0x10 unchanged after release.
- **Back-to-back on port 1:** SH 0xBEEF @0x22 then LH @0x22 → 0xFFFFBEEF. Port 0 stays idle and never sees `req_ready`.
